// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver.
//   slot_state_t : per-slot phase, BLANK (dead-time) or SHOW (digit lit)
//   SEG_BLANK    : active-low segment pattern with every segment off
package seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } slot_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage : seg_pkg

// File: rtl/seg_disp.sv
// Hex nibble to active-low 7-segment decoder (purely combinational).
//   hex   in  4  value 0..F
//   seg_c out 7  {g,f,e,d,c,b,a}, 0 = segment lit
module seg_disp (
    input  logic [3:0] hex,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = 7'b1111111;
        unique case (hex)
            4'h0: seg_c = 7'b1000000;
            4'h1: seg_c = 7'b1111001;
            4'h2: seg_c = 7'b0100100;
            4'h3: seg_c = 7'b0110000;
            4'h4: seg_c = 7'b0011001;
            4'h5: seg_c = 7'b0010010;
            4'h6: seg_c = 7'b0000010;
            4'h7: seg_c = 7'b1111000;
            4'h8: seg_c = 7'b0000000;
            4'h9: seg_c = 7'b0010000;
            4'hA: seg_c = 7'b0001000;
            4'hB: seg_c = 7'b0000011;
            4'hC: seg_c = 7'b1000110;
            4'hD: seg_c = 7'b0100001;
            4'hE: seg_c = 7'b0000110;
            4'hF: seg_c = 7'b0001110;
            default: seg_c = 7'b1111111;
        endcase
    end

endmodule : seg_disp

// File: rtl/seg_mux_disp.sv
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
// One shared segment bus is cycled across the digits, each slot starting with a
// dead-time to prevent ghosting, with optional leading-zero blanking.
//   clk, reset   clock, synchronous active-high reset
//   digits       hex nibbles, digit i = digits[4i+3:4i] (digit 0 least significant)
//   en           0 forces all anodes inactive (slot timing keeps running)
//   lz_blank     1 enables leading-zero blanking (digit 0 is never blanked)
//   seg          registered active-low segments {g..a}
//   anode        registered one-hot-active digit enables, polarity by ANODE_ACTIVE_LOW
//   digit_idx    index of the current slot
//   slot_strobe  high on the last cycle of each slot
module seg_mux_disp
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS       = 2,
    parameter int unsigned REFRESH_DIV      = 24000,
    parameter int unsigned BLANK_CYCLES     = 240,
    parameter bit          ANODE_ACTIVE_LOW = 1'b1,
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    en,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [IW-1:0]           digit_idx,
    output logic                    slot_strobe
);

    localparam int unsigned DW = 4 * NUM_DIGITS;
    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = ANODE_ACTIVE_LOW ? '1 : '0;
    localparam logic ANODE_ON = ANODE_ACTIVE_LOW ? 1'b0 : 1'b1;

    // Reject parameter combinations the slot timing cannot honour.
    if (BLANK_CYCLES >= REFRESH_DIV || NUM_DIGITS < 1 || NUM_DIGITS > 8 || REFRESH_DIV < 2) begin : g_param_check
        $error("seg_mux_disp: illegal NUM_DIGITS/REFRESH_DIV/BLANK_CYCLES combination");
    end

    logic [CW-1:0]         cnt, cnt_next;
    logic [IW-1:0]         idx, idx_next;
    slot_state_t           state, state_next;
    logic [DW-1:0]         snap, snap_next;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] anode_next;
    logic [3:0]            nibble;
    logic [6:0]            nibble_seg;
    logic                  lead_zero;
    logic                  wrap;

    seg_disp u_seg_disp (
        .hex   (nibble),
        .seg_c (nibble_seg)
    );

    // State register: counter, slot index, phase, digit snapshot and output regs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            idx   <= '0;
            state <= BLANK;
            snap  <= '0;
            seg   <= SEG_BLANK;
            anode <= ANODE_OFF;
        end else begin
            cnt   <= cnt_next;
            idx   <= idx_next;
            state <= state_next;
            snap  <= snap_next;
            seg   <= seg_next;
            anode <= anode_next;
        end
    end

    // Nibble mux and leading-zero detect for the current slot.
    always_comb begin
        logic upper_zero;
        nibble     = 4'h0;
        lead_zero  = 1'b0;
        upper_zero = 1'b1;
        // Walk from the most significant digit down so upper_zero covers idx..N-1.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (snap[4*i +: 4] == 4'h0);
            if (idx == IW'(i)) begin
                nibble    = snap[4*i +: 4];
                lead_zero = upper_zero & (i != 0);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        wrap       = (cnt == CNT_LAST);
        cnt_next   = wrap ? '0 : cnt + CW'(1);
        idx_next   = idx;
        snap_next  = snap;
        seg_next   = SEG_BLANK;
        anode_next = ANODE_OFF;

        if (wrap) begin
            idx_next  = (idx == IDX_LAST) ? '0 : idx + IW'(1);
            snap_next = digits;
        end

        // Phase follows the counter value the next cycle will hold.
        state_next = (cnt_next < CNT_BLANK) ? BLANK : SHOW;

        if (state == SHOW && en && !(lz_blank && lead_zero)) begin
            seg_next = nibble_seg;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx == IW'(i)) begin
                    anode_next[i] = ANODE_ON;
                end
            end
        end
    end

    assign digit_idx   = idx;
    assign slot_strobe = (cnt == CNT_LAST);

endmodule : seg_mux_disp

// File: tb/tb_seg_mux_disp.sv
// Scoreboard bench for seg_mux_disp (4 digits, 8-cycle slots, 2-cycle dead-time).
// A reference model predicts the outputs after every clock edge from elapsed time
// since reset; a monitor pops and compares those predictions against the DUT.
module tb_seg_mux_disp;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        lz_blank;
    logic [15:0] digits;
    logic [6:0]  seg;
    logic [3:0]  anode;
    logic [1:0]  digit_idx;
    logic        slot_strobe;

    typedef struct packed {
        logic [3:0] anode;
        logic [6:0] seg;
        logic [1:0] idx;
        logic       strobe;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned m_t = 0;
    logic [15:0] m_snap = 16'h0;
    bit          started = 1'b0;
    logic [6:0]  hex_tab [16];

    seg_mux_disp #(
        .NUM_DIGITS      (ND),
        .REFRESH_DIV     (RD),
        .BLANK_CYCLES    (BC),
        .ANODE_ACTIVE_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .en         (en),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .anode      (anode),
        .digit_idx  (digit_idx),
        .slot_strobe(slot_strobe)
    );

    always #5 clk = ~clk;

    // Reference model: predicts the outputs present just after each rising edge.
    always @(posedge clk) begin : model
        exp_t        e;
        int unsigned pcnt;
        int unsigned pidx;
        logic [3:0]  nib;
        bit          blank;
        if (reset) begin
            started = 1'b1;
            m_t     = 0;
            m_snap  = 16'h0;
            e.anode  = 4'hF;
            e.seg    = 7'h7F;
            e.idx    = 2'd0;
            e.strobe = 1'b0;
            expq.push_back(e);
        end else if (started) begin
            pcnt  = m_t % RD;
            pidx  = (m_t / RD) % ND;
            nib   = 4'(m_snap >> (4 * pidx));
            blank = (pcnt < BC) || !en ||
                    (lz_blank && pidx != 0 && (m_snap >> (4 * pidx)) == 16'h0);
            if (blank) begin
                e.anode = 4'hF;
                e.seg   = 7'h7F;
            end else begin
                e.anode = ~(4'b0001 << pidx);
                e.seg   = hex_tab[nib];
            end
            if (pcnt == RD - 1) m_snap = digits;
            m_t      = m_t + 1;
            e.idx    = 2'((m_t / RD) % ND);
            e.strobe = ((m_t % RD) == RD - 1);
            expq.push_back(e);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs shortly after every edge against the scoreboard.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("anode", int'(anode), int'(e.anode));
            chk("seg", int'(seg), int'(e.seg));
            chk("digit_idx", int'(digit_idx), int'(e.idx));
            chk("slot_strobe", int'(slot_strobe), int'(e.strobe));
            chk("anode_onehot", int'($countones(~anode) <= 1), 1);
        end
    end

    function automatic logic [15:0] rand_digits();
        logic [15:0] d;
        for (int i = 0; i < 4; i++) begin
            d[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        end
        return d;
    endfunction

    initial begin
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        reset    = 1'b1;
        en       = 1'b0;
        lz_blank = 1'b0;
        digits   = 16'h0;
        repeat (3) @(negedge clk);

        // Basic scan of 1234.
        reset  = 1'b0;
        digits = 16'h1234;
        en     = 1'b1;
        repeat (64) @(negedge clk);

        // Leading-zero blanking.
        lz_blank = 1'b1;
        digits   = 16'h0012;
        repeat (40) @(negedge clk);
        digits = 16'h0000;
        repeat (40) @(negedge clk);

        // Mid-slot digit change.
        lz_blank = 1'b0;
        digits   = 16'h1234;
        repeat (36) @(negedge clk);
        digits = 16'h5678;
        repeat (24) @(negedge clk);

        // Display disabled while timing runs on.
        en = 1'b0;
        repeat (20) @(negedge clk);
        en = 1'b1;
        repeat (21) @(negedge clk);

        // Reset mid-slot.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);

        // Randomised phase.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 11) == 0) digits = rand_digits();
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 29) == 0) lz_blank = ~lz_blank;
            reset = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);

        chk("queue_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seg_mux_disp
